mux_n_pipe: RTL and testbench

- Parametrised N-input, WIDTH-bit registered selector. Next-generation datapath mux for the 3-stage RV32I pipeline, used for operand and forwarding selection where the select arrives one or more cycles ahead of use.
- Adds a valid pipeline of 1 or 2 stages, a stall (hold) input and a flush (bubble) input.
- Detects select values at or above NUM_IN and flags them with an error bit plus a saturating error counter.

---
 rtl/mux_n_pipe.sv | 182 ++++++++++++++++++
 tb/tb_mux_n_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_n_pipe
//
// Purpose:
//   Registered N-input, WIDTH-bit selector with a 1- or 2-stage valid
//   pipeline, a stall (hold) input, a flush (bubble) input, and detection
//   of out-of-range select values. It serves operand and forwarding
//   selection in the 3-stage RV32I pipeline, where the select is known
//   one or more cycles before the data is used.
//
// Parameters:
//   WIDTH   data width of each input and of the output
//   NUM_IN  number of data inputs (2..16)
//   LAT     register stages from input to output (1 or 2)
//   SEL_W   select width, derived from NUM_IN
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed inputs; input k is in_data[k*WIDTH +: WIDTH]
//   sel        binary select, sampled together with in_valid
//   in_valid   sel and in_data are valid this cycle
//   stall      freeze every stage; nothing is captured or advanced
//   flush      clear every valid bit at the next edge (wins over stall)
//   out_data   selected data from the last stage
//   out_valid  out_data holds a live entry
//   out_err    the last-stage entry had sel >= NUM_IN (meaningful with out_valid)
//   err_count  saturating count of accepted out-of-range selects
//
// Every output is taken straight from a flop, so no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module mux_n_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  parameter  int LAT    = 1,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_err,
  output logic [7:0]              err_count
);

  // ---------------------------------------------------------------------------
  // Front end: select decode and accept qualification
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mux_data_s;
  logic             sel_err_s;
  logic             accept_s;

  // Range check and one-hot OR mux; an out-of-range select matches no input,
  // so the mux output falls to zero on its own.
  always_comb begin
    sel_err_s  = (32'(sel) >= 32'(NUM_IN));
    mux_data_s = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      mux_data_s = mux_data_s |
                   ((32'(sel) == 32'(k)) ? in_data[k*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
  end

  // An entry enters stage 1 only when offered, not held, and not flushed.
  always_comb begin
    accept_s = in_valid & ~stall & ~flush;
  end

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data1_r;
  logic             valid1_r;
  logic             err1_r;

  // Stage 1 register: valid tracks every non-stalled edge, while data and
  // err move only on accept, so bubbles leave the previous payload in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_r  <= {WIDTH{1'b0}};
      valid1_r <= 1'b0;
      err1_r   <= 1'b0;
    end else if (flush) begin
      valid1_r <= 1'b0;
    end else if (stall) begin
      valid1_r <= valid1_r;
    end else begin
      valid1_r <= in_valid;
      if (in_valid) begin
        data1_r <= mux_data_s;
        err1_r  <= sel_err_s;
      end else begin
        data1_r <= data1_r;
        err1_r  <= err1_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter
  // ---------------------------------------------------------------------------
  logic [7:0] err_count_r;

  // Saturating counter of accepted out-of-range selects; it holds at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= 8'd0;
    end else if (accept_s && sel_err_s && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stage 2 and output selection
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] last_data_s;
  logic             last_valid_s;
  logic             last_err_s;

  generate
    if (LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] data2_r;
      logic             valid2_r;
      logic             err2_r;

      // Stage 2 register: it copies stage 1 only when stage 1 holds a live
      // entry, so a bubble in stage 1 never overwrites the held payload.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data2_r  <= {WIDTH{1'b0}};
          valid2_r <= 1'b0;
          err2_r   <= 1'b0;
        end else if (flush) begin
          valid2_r <= 1'b0;
        end else if (stall) begin
          valid2_r <= valid2_r;
        end else begin
          valid2_r <= valid1_r;
          if (valid1_r) begin
            data2_r <= data1_r;
            err2_r  <= err1_r;
          end else begin
            data2_r <= data2_r;
            err2_r  <= err2_r;
          end
        end
      end

      // The last stage is stage 2.
      always_comb begin
        last_data_s  = data2_r;
        last_valid_s = valid2_r;
        last_err_s   = err2_r;
      end
    end else begin : g_lat1
      // The last stage is stage 1.
      always_comb begin
        last_data_s  = data1_r;
        last_valid_s = valid1_r;
        last_err_s   = err1_r;
      end
    end
  endgenerate

  // The outputs connect directly to the last-stage flops.
  always_comb begin
    out_data  = last_data_s;
    out_valid = last_valid_s;
    out_err   = last_err_s;
    err_count = err_count_r;
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
`timescale 1ns/1ps
// Testbench for mux_n_pipe: three instances (LAT=1/NUM_IN=4, LAT=2/NUM_IN=4,
// LAT=1/NUM_IN=3) share one stimulus stream and are compared every cycle
// against a stage-list reference model.
module tb_mux_n_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [1:0]  sel;
  logic [31:0] din [4];

  wire [127:0] data4 = {din[3], din[2], din[1], din[0]};
  wire [95:0]  data3 = {din[2], din[1], din[0]};

  logic [31:0] od [3];
  logic        ov [3];
  logic        oe [3];
  logic [7:0]  oc [3];

  int lat [3] = '{1, 2, 1};
  int nin [3] = '{4, 4, 3};

  // Reference model: each instance is a list of stage slots plus a counter.
  logic [31:0] m_data  [3][2];
  bit          m_valid [3][2];
  bit          m_err   [3][2];
  int          m_cnt   [3];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(data4), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(od[0]), .out_valid(ov[0]),
    .out_err(oe[0]), .err_count(oc[0]));

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(data4), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(od[1]), .out_valid(ov[1]),
    .out_err(oe[1]), .err_count(oc[1]));

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .LAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(data3), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(od[2]), .out_valid(ov[2]),
    .out_err(oe[2]), .err_count(oc[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 2; s++) begin
        m_data[i][s]  = 32'd0;
        m_valid[i][s] = 1'b0;
        m_err[i][s]   = 1'b0;
      end
      m_cnt[i] = 0;
    end
  endtask

  // Apply one rising edge to the model, using the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        for (int s = 0; s < 2; s++) begin
          m_data[i][s] = 32'd0; m_valid[i][s] = 1'b0; m_err[i][s] = 1'b0;
        end
        m_cnt[i] = 0;
      end else if (flush) begin
        for (int s = 0; s < 2; s++) m_valid[i][s] = 1'b0;
      end else if (!stall) begin
        for (int s = lat[i] - 1; s > 0; s--) begin
          if (m_valid[i][s-1]) begin
            m_data[i][s] = m_data[i][s-1];
            m_err[i][s]  = m_err[i][s-1];
          end
          m_valid[i][s] = m_valid[i][s-1];
        end
        m_valid[i][0] = in_valid;
        if (in_valid) begin
          if (int'(sel) < nin[i]) begin
            m_data[i][0] = din[sel];
            m_err[i][0]  = 1'b0;
          end else begin
            m_data[i][0] = 32'd0;
            m_err[i][0]  = 1'b1;
            if (m_cnt[i] < 255) m_cnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.out_data", i),  od[i],        m_data[i][lat[i]-1]);
      chk($sformatf("u%0d.out_valid", i), 32'(ov[i]),   32'(m_valid[i][lat[i]-1]));
      chk($sformatf("u%0d.out_err", i),   32'(oe[i]),   32'(m_err[i][lat[i]-1]));
      chk($sformatf("u%0d.err_count", i), 32'(oc[i]),   32'(m_cnt[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; sel = 2'd0;
    din[0] = 32'h11; din[1] = 32'h22; din[2] = 32'h33; din[3] = 32'h44;
    model_reset();
    #1;
    check_all();
    step();
    step();
    rst_n = 1'b1;

    // Single accept with LAT=1: data appears one edge later, then a bubble.
    sel = 2'd2; in_valid = 1'b1;
    step();
    chk("tp1_data", od[0], 32'h33);
    chk("tp1_valid", 32'(ov[0]), 32'd1);
    in_valid = 1'b0;
    step();
    chk("tp1_bubble_valid", 32'(ov[0]), 32'd0);
    chk("tp1_bubble_data", od[0], 32'h33);

    // Back-to-back accepts through the LAT=2 instance.
    in_valid = 1'b1;
    sel = 2'd0; step();
    sel = 2'd1; step();
    chk("tp2_first", od[1], 32'h11);
    sel = 2'd3; step();
    chk("tp2_second", od[1], 32'h22);
    in_valid = 1'b0;
    step();
    chk("tp2_third", od[1], 32'h44);
    step(); step();

    // Stall with a pending entry offered: nothing is captured or advanced.
    in_valid = 1'b1; sel = 2'd1; stall = 1'b1;
    step(); step(); step();
    stall = 1'b0; in_valid = 1'b0;
    step(); step(); step();

    // Flush with stall, with an entry offered, while two are in flight.
    in_valid = 1'b1;
    sel = 2'd0; step();
    sel = 2'd1; step();
    flush = 1'b1; stall = 1'b1; sel = 2'd2;
    step();
    chk("flush_valid", 32'(ov[1]), 32'd0);
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    step(); step(); step();

    // Out-of-range select on the NUM_IN=3 instance up to saturation.
    sel = 2'd3; in_valid = 1'b1;
    for (int n = 0; n < 301; n++) step();
    chk("sat_count", 32'(oc[2]), 32'd255);
    chk("sat_err", 32'(oe[2]), 32'd1);
    chk("sat_data", od[2], 32'd0);
    in_valid = 1'b0;
    step();

    // Asynchronous reset between clock edges, then recovery.
    in_valid = 1'b1; sel = 2'd1;
    step(); step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_rst_count", 32'(oc[2]), 32'd0);
    step();
    rst_n = 1'b1;
    sel = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < 4; k++) din[k] = $urandom;
      sel      = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
